// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: sequences camera pixels into the RAM write port and
// arbitrates the single RAM read port between display (priority) and processing.
module frame_buffer_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 19
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          CamVsync,
    input  logic          CamPixelValid,
    input  logic          CamPixel,
    output logic          WriteEnable,
    output logic [AW-1:0] WriteAddr,
    output logic          DataIn,
    output logic [AW-1:0] ReadAddr,
    input  logic          DataOut,
    input  logic          DispReq,
    input  logic [AW-1:0] DispAddr,
    output logic          DispData,
    output logic          DispValid,
    input  logic          ProcReq,
    input  logic [AW-1:0] ProcAddr,
    output logic          ProcGrant,
    output logic          ProcData,
    output logic          ProcValid,
    output logic          Capturing,
    output logic          FrameDone,
    output logic [7:0]    FrameCount,
    output logic          Overflow
);

    localparam int            NPIX      = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW:0]   NPIX_W    = (AW + 1)'(NPIX);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } wr_state_e;

    wr_state_e     state_q, state_d;
    logic          vsync_q, vsync_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          din_q, din_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          overflow_q, overflow_d;
    logic          rise_s;

    logic [AW-1:0] raddr_q, raddr_d;
    logic          disp_v1_q, disp_v1_d, proc_v1_q, proc_v1_d, oor1_q, oor1_d;
    logic          disp_v2_q, disp_v2_d, proc_v2_q, proc_v2_d, oor2_q, oor2_d;
    logic          disp_sel_s, proc_sel_s, in_range_s;
    logic [AW-1:0] sel_addr_s;

    // Capture sequencing: edge detect, pixel counter, frame completion and overflow
    always_comb begin
        vsync_d       = CamVsync;
        rise_s        = CamVsync & ~vsync_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        din_d         = din_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = {AW{1'b0}};
                end else if (CamPixelValid) begin
                    overflow_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // A new frame start restarts the frame; a coincident pixel is dropped
                if (rise_s) begin
                    cnt_d = {AW{1'b0}};
                end else if (CamPixelValid) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    din_d   = CamPixel;
                    if (cnt_q == LAST_ADDR) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        state_d       = ST_IDLE;
                        cnt_d         = {AW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // Read arbitration and the two-stage ownership pipeline that follows the RAM
    always_comb begin
        disp_sel_s = DispReq & ~Reset;
        proc_sel_s = ProcReq & ~DispReq & ~Reset;
        sel_addr_s = DispReq ? DispAddr : ProcAddr;
        in_range_s = ({1'b0, sel_addr_s} < NPIX_W);
        if ((disp_sel_s | proc_sel_s) & in_range_s) begin
            raddr_d = sel_addr_s;
        end else begin
            raddr_d = raddr_q;
        end
        // Out-of-range grants keep valid but never present an address to the RAM
        disp_v1_d = disp_sel_s;
        proc_v1_d = proc_sel_s;
        oor1_d    = (disp_sel_s | proc_sel_s) & ~in_range_s;
        disp_v2_d = disp_v1_q;
        proc_v2_d = proc_v1_q;
        oor2_d    = oor1_q;
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            cnt_q         <= {AW{1'b0}};
            we_q          <= 1'b0;
            waddr_q       <= {AW{1'b0}};
            din_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            overflow_q    <= 1'b0;
            raddr_q       <= {AW{1'b0}};
            disp_v1_q     <= 1'b0;
            proc_v1_q     <= 1'b0;
            oor1_q        <= 1'b0;
            disp_v2_q     <= 1'b0;
            proc_v2_q     <= 1'b0;
            oor2_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            din_q         <= din_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            raddr_q       <= raddr_d;
            disp_v1_q     <= disp_v1_d;
            proc_v1_q     <= proc_v1_d;
            oor1_q        <= oor1_d;
            disp_v2_q     <= disp_v2_d;
            proc_v2_q     <= proc_v2_d;
            oor2_q        <= oor2_d;
        end
    end

    assign WriteEnable = we_q;
    assign WriteAddr   = waddr_q;
    assign DataIn      = din_q;
    assign ReadAddr    = raddr_q;
    assign ProcGrant   = proc_sel_s;
    assign DispValid   = disp_v2_q;
    assign ProcValid   = proc_v2_q;
    assign DispData    = disp_v2_q & ~oor2_q & DataOut;
    assign ProcData    = proc_v2_q & ~oor2_q & DataOut;
    assign Capturing   = (state_q == ST_CAPTURE);
    assign FrameDone   = frame_done_q;
    assign FrameCount  = frame_count_q;
    assign Overflow    = overflow_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl on a reduced 10x6 frame (AW=6 leaves 60..63 out of range)
// with a behavioural model of capture, frame memory and read routing.
module tb_frame_buffer_ctrl;

    localparam int W    = 10;
    localparam int H    = 6;
    localparam int AW   = 6;
    localparam int NPIX = W * H;

    logic          Clock = 1'b0;
    logic          Reset, CamVsync, CamPixelValid, CamPixel, DataOut;
    logic          DispReq, ProcReq;
    logic [AW-1:0] DispAddr, ProcAddr;
    logic          WriteEnable, DataIn, DispData, DispValid, ProcGrant, ProcData, ProcValid;
    logic          Capturing, FrameDone, Overflow;
    logic [AW-1:0] WriteAddr, ReadAddr;
    logic [7:0]    FrameCount;

    always #5 Clock = ~Clock;

    frame_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .Clock(Clock), .Reset(Reset), .CamVsync(CamVsync), .CamPixelValid(CamPixelValid),
        .CamPixel(CamPixel), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .DataIn(DataIn),
        .ReadAddr(ReadAddr), .DataOut(DataOut), .DispReq(DispReq), .DispAddr(DispAddr),
        .DispData(DispData), .DispValid(DispValid), .ProcReq(ProcReq), .ProcAddr(ProcAddr),
        .ProcGrant(ProcGrant), .ProcData(ProcData), .ProcValid(ProcValid),
        .Capturing(Capturing), .FrameDone(FrameDone), .FrameCount(FrameCount),
        .Overflow(Overflow)
    );

    // RAM with registered read and old-data behaviour on read/write collisions
    logic ram [0:(1<<AW)-1];
    always @(posedge Clock) begin
        if (WriteEnable) ram[WriteAddr] <= DataIn;
        DataOut <= ram[ReadAddr];
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: frame-level view of capture plus expected image contents
    bit m_inframe = 1'b0;
    int m_next    = 0;
    int m_fc      = 0;
    bit m_ovf     = 1'b0;
    bit m_prev_vs = 1'b0;
    bit ref_mem [0:NPIX-1];
    int p1_own    = 0;   // 0 none, 1 display, 2 processing: read granted one cycle ago
    bit p1_data   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int own, a, e_waddr;
        bit inr, rdat, e_we, e_din, e_fd, edge_s, was_rst;
        #1;
        own = 0;
        a = 0;
        was_rst = Reset;
        if (!Reset) begin
            if (DispReq) begin own = 1; a = int'(DispAddr); end
            else if (ProcReq) begin own = 2; a = int'(ProcAddr); end
        end
        chk("proc_grant", 32'(ProcGrant), 32'(own == 2));
        inr  = (a < NPIX);
        rdat = (own != 0 && inr) ? ref_mem[a] : 1'b0;
        e_we = 1'b0; e_din = 1'b0; e_fd = 1'b0; e_waddr = 0;
        if (Reset) begin
            m_inframe = 1'b0; m_next = 0; m_fc = 0; m_ovf = 1'b0; m_prev_vs = 1'b0;
            p1_own = 0;
        end else begin
            edge_s    = CamVsync && !m_prev_vs;
            m_prev_vs = CamVsync;
            if (edge_s) begin
                m_inframe = 1'b1;
                m_next    = 0;
            end else if (CamPixelValid) begin
                if (!m_inframe) begin
                    m_ovf = 1'b1;
                end else begin
                    e_we = 1'b1; e_waddr = m_next; e_din = CamPixel;
                    ref_mem[m_next] = CamPixel;
                    if (m_next == NPIX - 1) begin
                        e_fd = 1'b1; m_fc = (m_fc + 1) % 256; m_inframe = 1'b0; m_next = 0;
                    end else begin
                        m_next++;
                    end
                end
            end
        end
        @(posedge Clock);
        #1;
        chk("write_enable", 32'(WriteEnable), 32'(e_we));
        if (e_we) begin
            chk("write_addr", 32'(WriteAddr), 32'(e_waddr));
            chk("data_in", 32'(DataIn), 32'(e_din));
        end
        if (was_rst) begin
            chk("rst_write_addr", 32'(WriteAddr), 32'd0);
            chk("rst_data_in", 32'(DataIn), 32'd0);
            chk("rst_read_addr", 32'(ReadAddr), 32'd0);
        end
        chk("frame_done", 32'(FrameDone), 32'(e_fd));
        chk("frame_count", 32'(FrameCount), 32'(m_fc));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("capturing", 32'(Capturing), 32'(m_inframe));
        chk("disp_valid", 32'(DispValid), 32'(p1_own == 1));
        chk("disp_data", 32'(DispData), 32'((p1_own == 1) ? p1_data : 1'b0));
        chk("proc_valid", 32'(ProcValid), 32'(p1_own == 2));
        chk("proc_data", 32'(ProcData), 32'((p1_own == 2) ? p1_data : 1'b0));
        if (own != 0 && inr) chk("read_addr", 32'(ReadAddr), 32'(a));
        p1_own  = own;
        p1_data = rdat;
    endtask

    task automatic put(input bit rst, input bit vs, input bit pv, input bit px,
                       input bit dr, input int da, input bit pr, input int pa);
        Reset = rst; CamVsync = vs; CamPixelValid = pv; CamPixel = px;
        DispReq = dr; DispAddr = AW'(da); ProcReq = pr; ProcAddr = AW'(pa);
        cycle();
    endtask

    initial begin
        bit keep, vs;
        put(1, 0, 0, 0, 0, 0, 0, 0);
        put(1, 0, 0, 0, 0, 0, 0, 0);
        put(0, 0, 0, 0, 0, 0, 0, 0);

        // Full frame at one pixel per clock, pixel value = address bit 0
        put(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NPIX; i++) put(0, 1, 1, i[0], 0, 0, 0, 0);
        put(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fc_after_frame", 32'(FrameCount), 32'd1);
        chk("cap_after_frame", 32'(Capturing), 32'd0);
        chk("ovf_after_frame", 32'(Overflow), 32'd0);

        // Strobes while idle are not written and set the sticky overflow
        for (int i = 0; i < 3; i++) put(0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) put(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(Overflow), 32'd1);

        // Mid-frame restart with a coincident strobe, then complete the frame
        put(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) put(0, 1, 1, ~i[0], 0, 0, 0, 0);
        put(0, 0, 1, 1, 0, 0, 0, 0);
        put(0, 1, 1, 1, 0, 0, 0, 0);
        chk("fc_after_abort", 32'(FrameCount), 32'd1);
        for (int i = 0; i < NPIX; i++) put(0, 1, 1, ($urandom_range(0, 1) == 1), 0, 0, 0, 0);
        chk("fc_second_frame", 32'(FrameCount), 32'd2);

        // Display priority over a held processing request
        for (int i = 0; i < 3; i++) put(0, 0, 0, 0, 1, 7, 1, 5);
        put(0, 0, 0, 0, 0, 0, 1, 5);
        for (int i = 0; i < 3; i++) put(0, 0, 0, 0, 0, 0, 0, 0);

        // Out-of-range reads return zero with valid
        put(0, 0, 0, 0, 1, 60, 0, 0);
        put(0, 0, 0, 0, 0, 0, 1, 63);
        put(0, 0, 0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 3; i++) put(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during capture with reads in flight
        put(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) put(0, 1, 1, i[1], i[0], i, ~i[0], 59 - i);
        put(1, 1, 1, 1, 1, 3, 1, 4);
        put(0, 0, 0, 0, 0, 0, 0, 0);
        put(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic; processing requests are held until granted
        vs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            keep = ProcReq && DispReq && !Reset;
            if ($urandom_range(0, 99) == 0) vs = ~vs;
            Reset         = ($urandom_range(0, 299) == 0);
            CamVsync      = vs;
            CamPixelValid = ($urandom_range(0, 3) != 0);
            CamPixel      = ($urandom_range(0, 1) == 1);
            DispReq       = ($urandom_range(0, 2) == 0);
            DispAddr      = AW'($urandom_range(0, 63));
            if (!keep) begin
                ProcReq  = ($urandom_range(0, 1) == 1);
                ProcAddr = AW'($urandom_range(0, 63));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
